cla_mp_sequencer: RTL

Multi-precision add/subtract controller that time-shares a single 8-bit carry-lookahead adder across the bytes of a wide operand. It accepts one NBYTES-wide operation per handshake, walks the bytes LSB-first through one `cla_8bit` instance with a registered inter-byte carry, and presents the assembled result and flags on a valid/ready output port. It sits between the ALU operand registers and the result writeback, so wide adds need no wider adder.

---
 rtl/cla_seq_pkg.sv | 23 ++
 rtl/cla_8bit.sv | 49 ++++
 rtl/cla_mp_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg -- shared definitions for the multi-precision add/subtract
// sequencer (cla_mp_sequencer) and its helpers.
//   - FSM state constants IDLE / RUN / DONE
//   - operation encoding OP_ADD / OP_SUB
//   - idx_width(): width of the byte-index counter for a given byte count
// No ports (package).
package cla_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // op input encoding
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Byte-index width; never narrower than one bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/cla_8bit.sv
// cla_8bit -- combinational 8-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  8  addends
//   cin   in  1  carry in
//   sum   out 8  a + b + cin (mod 256)
//   cout  out 1  carry out of bit 7
//   c7    out 1  carry into bit 7 (used for signed overflow detection)
// The upper nibble's carry-in comes from the lower nibble's group
// generate/propagate terms, so the two nibbles resolve in parallel.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gg_lo;
  logic       gp_lo;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate of the low nibble
  assign gg_lo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp_lo = &p[3:0];

  // Carry network: per-bit recurrence inside each nibble, lookahead across nibbles
  always_comb begin
    c    = 9'd0;
    c[0] = cin;
    for (int i = 0; i < 3; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    c[4] = gg_lo | (gp_lo & cin);
    for (int i = 4; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
  assign c7   = c[7];

endmodule

// File: rtl/cla_mp_sequencer.sv
// cla_mp_sequencer -- multi-precision add/subtract controller that reuses one
// cla_8bit slice across all bytes of a W = 8*NBYTES operand, LSB first.
// Optional feature macro: CLA_SEQ_FLAGS_EN (defined -> ovf/zero computed;
// undefined -> ovf/zero tied low, ports kept).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready = IDLE decode)
//   op                  0 add, 1 subtract (a - b)
//   a, b   [W]          operands, sampled at accept
//   cin                 add carry-in, ignored for subtract
//   out_valid/out_ready result handshake (out_valid = DONE decode)
//   result [W]          sum / difference
//   cout                carry out of MSB slice (subtract: 1 = no borrow)
//   ovf                 signed overflow
//   zero                result == 0
module cla_mp_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                zero
);

  localparam int             W    = 8 * NBYTES;
  localparam int             IW   = idx_width(NBYTES);
  localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_hold;
  logic [W-1:0]  b_hold;      // already inverted for subtract
  logic          carry_reg;
  logic [W-1:0]  result_reg;
  logic          cout_reg;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    sum_byte;
  logic          slice_cout;
  logic          slice_c7;
  logic [W-1:0]  res_next;
  logic          last_slice;

  assign a_byte     = a_hold[idx*8 +: 8];
  assign b_byte     = b_hold[idx*8 +: 8];
  assign last_slice = (state == RUN) && (idx == LAST);

  cla_8bit u_cla (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_reg),
    .sum  (sum_byte),
    .cout (slice_cout),
    .c7   (slice_c7)
  );

  // Result with the current slice's byte merged in
  always_comb begin
    res_next             = result_reg;
    res_next[idx*8 +: 8] = sum_byte;
  end

  // Sequencer FSM, operand capture and byte-serial accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_hold     <= '0;
      b_hold     <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_hold    <= a;
            b_hold    <= b ^ {W{op}};
            // subtract = a + ~b + 1
            carry_reg <= (op == OP_SUB) ? 1'b1 : cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result_reg <= res_next;
          carry_reg  <= slice_cout;
          if (idx == LAST) begin
            cout_reg <= slice_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLA_SEQ_FLAGS_EN
  logic ovf_reg;
  logic zero_reg;

  // Flags captured from the final slice alongside cout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (last_slice) begin
      ovf_reg  <= slice_c7 ^ slice_cout;
      zero_reg <= (res_next == '0);
    end
  end

  assign ovf  = ovf_reg;
  assign zero = zero_reg;
`else
  logic unused_flags;
  assign unused_flags = slice_c7 & last_slice;
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_reg;
  assign cout      = cout_reg;

endmodule
